wt_store_wbuf: RTL

// - Store write buffer for the write-through dcache (WT type) of the 32-bit IMAC/Sv32 core.
// - Sits between the store unit commit port (upstream) and the dcache memory/NoC adapter (downstream).
// - Holds committed stores and issues them in order, one word per request, tagged with a transaction id.
// - Retires each store on ack. Reports pending-store address hits so loads can be held back.

---
 rtl/wt_wbuf_pkg.sv | 29 ++
 rtl/wt_wbuf_match.sv | 37 +++
 rtl/wt_store_wbuf.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/wt_wbuf_pkg.sv
// Shared types and constants for the write-through store write buffer.
package wt_wbuf_pkg;

    localparam int WBUF_DEPTH  = 8;
    localparam int WBUF_PLEN   = 34;
    localparam int WBUF_DATA_W = 32;
    localparam int WBUF_TID_W  = 2;
    localparam int WBUF_WORD_W = WBUF_PLEN - 2;
    localparam int WBUF_BE_W   = WBUF_DATA_W / 8;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        VALID    = 2'd1,
        INFLIGHT = 2'd2
    } wbuf_state_e;

    typedef struct packed {
        logic [WBUF_WORD_W-1:0] waddr;
        logic [WBUF_DATA_W-1:0] data;
        logic [WBUF_BE_W-1:0]   be;
        logic                   nc;
        wbuf_state_e            state;
    } wbuf_entry_t;

    function automatic logic [WBUF_WORD_W-1:0] word_of(input logic [WBUF_PLEN-1:0] addr);
        return addr[WBUF_PLEN-1:2];
    endfunction

endpackage

// File: rtl/wt_wbuf_match.sv
// Per-entry word compare with youngest-match select (one-hot), ordered relative to wr_ptr.
module wt_wbuf_match #(
    parameter int DEPTH  = 8,
    parameter int WORD_W = 32,
    parameter int PTR_W  = 3
) (
    input  logic [DEPTH-1:0][WORD_W-1:0] words_i,
    input  logic [DEPTH-1:0]             elig_i,
    input  logic [WORD_W-1:0]            cmp_word_i,
    input  logic [PTR_W-1:0]             wr_ptr_i,
    output logic [DEPTH-1:0]             sel_o
);

    logic [DEPTH-1:0] hit;
    logic [PTR_W-1:0] cand;

    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = elig_i[i] && (words_i[i] == cmp_word_i);
        end
    end

    // Walk oldest (wr_ptr) to youngest (wr_ptr-1); the last hit wins.
    always_comb begin
        sel_o = '0;
        cand  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            cand = wr_ptr_i - PTR_W'(k);
            if (hit[cand]) begin
                sel_o       = '0;
                sel_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wt_store_wbuf.sv
// In-order store write buffer for the WT dcache: alloc, tagged issue, ack retire, load hit check.
// Optional byte merging of cacheable stores is enabled by defining WT_WBUF_MERGE_EN.
module wt_store_wbuf
    import wt_wbuf_pkg::*;
#(
    parameter int DEPTH  = WBUF_DEPTH,
    parameter int PLEN   = WBUF_PLEN,
    parameter int DATA_W = WBUF_DATA_W,
    parameter int TID_W  = WBUF_TID_W
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                st_valid_i,
    output logic                st_ready_o,
    input  logic [PLEN-1:0]     st_addr_i,
    input  logic [DATA_W-1:0]   st_data_i,
    input  logic [DATA_W/8-1:0] st_be_i,
    input  logic                st_nc_i,
    output logic                mem_req_o,
    input  logic                mem_gnt_i,
    output logic [PLEN-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]   mem_data_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic                mem_nc_o,
    output logic [TID_W-1:0]    mem_tid_o,
    input  logic                mem_ack_i,
    input  logic [TID_W-1:0]    mem_ack_tid_i,
    input  logic [PLEN-1:0]     chk_addr_i,
    output logic                chk_hit_o,
    output logic                empty_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int WORD_W = PLEN - 2;
    localparam int CNT_W  = TID_W + 1;
    localparam logic [CNT_W-1:0] MAX_INFL =
        CNT_W'((DEPTH < (2 ** TID_W)) ? DEPTH : (2 ** TID_W));

    wbuf_entry_t                    entries [DEPTH];
    logic [PTR_W-1:0]               wr_ptr, iss_ptr, ret_ptr;
    logic [CNT_W-1:0]               inflight_cnt;
    logic [DEPTH-1:0][WORD_W-1:0]   words;
    logic [DEPTH-1:0]               busy_mask, infl_mask;
    logic [DEPTH-1:0]               busy_sel, infl_sel, merge_sel;
    logic                           full, merge_hit, do_alloc, do_merge;
    logic                           iss_fire, ack_fire;

    always_comb begin
        words     = '0;
        busy_mask = '0;
        infl_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            words[i]     = entries[i].waddr;
            busy_mask[i] = (entries[i].state != FREE);
            infl_mask[i] = (entries[i].state == INFLIGHT);
        end
    end

    wt_wbuf_match #(.DEPTH(DEPTH), .WORD_W(WORD_W), .PTR_W(PTR_W)) u_chk_match (
        .words_i    (words),
        .elig_i     (busy_mask),
        .cmp_word_i (word_of(chk_addr_i)),
        .wr_ptr_i   (wr_ptr),
        .sel_o      (busy_sel)
    );

    wt_wbuf_match #(.DEPTH(DEPTH), .WORD_W(WORD_W), .PTR_W(PTR_W)) u_haz_match (
        .words_i    (words),
        .elig_i     (infl_mask),
        .cmp_word_i (entries[iss_ptr].waddr),
        .wr_ptr_i   (wr_ptr),
        .sel_o      (infl_sel)
    );

    assign full      = busy_mask[wr_ptr];
    assign mem_req_o = (entries[iss_ptr].state == VALID) && (inflight_cnt < MAX_INFL)
                       && !(|infl_sel);
    assign iss_fire  = mem_req_o && mem_gnt_i;
    assign ack_fire  = mem_ack_i && (inflight_cnt != '0)
                       && (mem_ack_tid_i == ret_ptr[TID_W-1:0]);

`ifdef WT_WBUF_MERGE_EN
    logic [DEPTH-1:0] merge_mask;

    // The entry being granted this cycle is already on its way out; a store to it allocates.
    always_comb begin
        merge_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            merge_mask[i] = (entries[i].state == VALID) && !entries[i].nc
                            && !(iss_fire && (iss_ptr == PTR_W'(i)));
        end
    end

    wt_wbuf_match #(.DEPTH(DEPTH), .WORD_W(WORD_W), .PTR_W(PTR_W)) u_merge_match (
        .words_i    (words),
        .elig_i     (merge_mask),
        .cmp_word_i (word_of(st_addr_i)),
        .wr_ptr_i   (wr_ptr),
        .sel_o      (merge_sel)
    );

    assign merge_hit = (|merge_sel) && !st_nc_i;
`else
    assign merge_sel = '0;
    assign merge_hit = 1'b0;
`endif

    assign st_ready_o = !full || merge_hit;
    assign do_merge   = st_valid_i && merge_hit;
    assign do_alloc   = st_valid_i && !merge_hit && !full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_alloc && (wr_ptr == PTR_W'(i))) begin
                    entries[i].waddr <= word_of(st_addr_i);
                    entries[i].data  <= st_data_i;
                    entries[i].be    <= st_be_i;
                    entries[i].nc    <= st_nc_i;
                    entries[i].state <= VALID;
                end
                if (do_merge && merge_sel[i]) begin
                    for (int b = 0; b < DATA_W / 8; b++) begin
                        if (st_be_i[b]) begin
                            entries[i].data[8*b +: 8] <= st_data_i[8*b +: 8];
                        end
                    end
                    entries[i].be <= entries[i].be | st_be_i;
                end
                if (iss_fire && (iss_ptr == PTR_W'(i))) begin
                    entries[i].state <= INFLIGHT;
                end
                if (ack_fire && (ret_ptr == PTR_W'(i))) begin
                    entries[i].state <= FREE;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr       <= '0;
            iss_ptr      <= '0;
            ret_ptr      <= '0;
            inflight_cnt <= '0;
        end else begin
            if (do_alloc) wr_ptr <= wr_ptr + 1'b1;
            if (iss_fire) iss_ptr <= iss_ptr + 1'b1;
            if (ack_fire) ret_ptr <= ret_ptr + 1'b1;
            case ({iss_fire, ack_fire})
                2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
                2'b01:   inflight_cnt <= inflight_cnt - 1'b1;
                default: inflight_cnt <= inflight_cnt;
            endcase
        end
    end

    assign mem_addr_o = {entries[iss_ptr].waddr, 2'b00};
    assign mem_data_o = entries[iss_ptr].data;
    assign mem_be_o   = entries[iss_ptr].be;
    assign mem_nc_o   = entries[iss_ptr].nc;
    assign mem_tid_o  = iss_ptr[TID_W-1:0];
    assign chk_hit_o  = |busy_sel;
    assign empty_o    = ~|busy_mask;

    ack_in_order_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_ack_i |-> ack_fire);

endmodule
